score_keeper: RTL
=================

Name: score_keeper

Overview:
Downstream consumer of the ball and falling-block position buses produced at the game top level. Once per video frame it scans every ball/block pair for overlap, awards points on hits, and charges a life when an unhit block reaches the screen bottom. Outputs a 4-digit BCD score for the HexDrivers, a lives count, a game-over flag and per-hit LED pulses.

Parameters:
NUM_BALLS, 2, number of player balls scanned
NUM_BLOCKS, 5, number of falling blocks scanned
SCREEN_Y_MAX, 479, last visible row; block bottom at or past this is a miss
START_LIVES, 3, lives loaded at reset (1..3)

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA vs (active-low vsync); its rising edge marks a frame boundary
ball_x  in  10*NUM_BALLS  ball centre X, ball i at bits [10i+9:10i]
ball_y  in  10*NUM_BALLS  ball centre Y
ball_s  in  10*NUM_BALLS  ball half-size
block_x  in  10*NUM_BLOCKS  block centre X
block_y  in  10*NUM_BLOCKS  block centre Y
block_s  in  10*NUM_BLOCKS  block half-size
block_ready  in  NUM_BLOCKS  block j active (falling)
score_bcd  out  16  four BCD digits, [3:0] = ones
lives  out  2  remaining lives
game_over  out  1  high once lives reach 0
hit_pulse  out  1  one Clk cycle high per scored hit
hit_mask  out  NUM_BLOCKS  blocks already hit in their current fall

Behaviour:
- Clock/reset: one clock, Clk; Reset asynchronous, active-high. Reset values: score_bcd=0, lives=START_LIVES, game_over=0, hit_pulse=0, hit_mask=0, all latches 0, FSM=IDLE.
- frame_clk synchronised by 2 flops; rising edge detected on the synchronised copy; frame_start is asserted 3 Clk cycles after the raw edge.
- FSM states: IDLE, SCAN, OVER.
  - IDLE: on frame_start, go to SCAN with pair index k=0.
  - SCAN: one pair per cycle; k = block*NUM_BALLS + ball; k runs 0..NUM_BALLS*NUM_BLOCKS-1, then return to IDLE. The scan takes 10 cycles at default parameters. frame_start during SCAN is ignored.
  - OVER: entered when lives reach 0. Absorbing state; only Reset leaves it. game_over=1; score, lives and hit_mask are frozen.
- Hit test at pair (j,i): requires block_ready[j]=1 and hit_mask[j]=0, and both |bx-xi| <= bs+si and |by-yi| <= bs+si.
  - Differences are computed at 11 bits signed; sums at 11 bits unsigned, with no wrap.
  - On a hit: set hit_mask[j], pulse hit_pulse for that cycle, and increment score_bcd by 1 in the same cycle.
  - A block scores at most once per fall, even if both balls overlap it.
- BCD increment: ripple carry over the 4 digits. Saturates at 9999 (stays 9999, hit_pulse still fires).
- Miss test: on the last-ball step of block j, with the hit result from the same cycle included. Requires block_ready[j]=1, hit_mask[j]=0, miss_latch[j]=0, and block_y+block_s >= SCREEN_Y_MAX (11-bit).
  - On a miss: set miss_latch[j] and decrement lives.
  - If lives was 1, go to OVER at the end of the scan.
  - A hit and reaching the bottom in the same frame counts as a hit, not a miss.
- Latch clear: on any scan step of block j where block_ready[j]=0, clear hit_mask[j] and miss_latch[j]. This re-arms the block for its next fall.
- Reset mid-scan: everything returns to reset values immediately; no partial update survives.

Decomposition:
- Shared package game_pkg holds:
  - constants SCREEN_Y_MAX and COORD_W=10
  - typedef coord_t (logic [9:0])
  - typedef bcd4_t (logic [15:0])
  - enum sk_state_t {IDLE, SCAN, OVER}
- One natural sub-module: bcd_counter4 (synchronous inc, saturate at 9999, async active-high Reset). It is reused by any later high-score display.

Test Plan:
- Reset: assert Reset for 2 cycles -> score_bcd=0x0000, lives=3, game_over=0, hit_mask=0, hit_pulse=0.
- Single hit: ball0 (300,400,s=10), block2 (300,405,s=12), ready=00100, one vs rising edge -> after scan score_bcd=0x0001, exactly one hit_pulse, hit_mask=00100. Repeat for 5 frames -> score stays 0x0001. Drop ready[2] for one frame, then raise again -> next overlap gives 0x0002.
- Double overlap: ball0 and ball1 both overlap block0 in one frame -> score +1 only, one hit_pulse.
- Miss and game over: block1 at y=470, s=10, ready, no overlap -> lives 3->2, one decrement over 4 frames. Repeat for blocks 3 and 4 -> lives=0, game_over=1. Further overlaps -> score unchanged.
- Boundary: |dx| = bs+si exactly (20) -> hit; 21 -> no hit. Block bottom at 478 -> no miss; 479 -> miss. Hit and bottom in the same frame -> score +1, lives unchanged.
- Saturation and reset: preload to 9998, then 3 hits -> 9999 with 3 hit_pulses. Assert Reset during cycle 5 of a scan -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types and constants used by the scoring logic and
// any later display blocks.
package game_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCREEN_Y_MAX = 479;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [15:0]        bcd4_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OVER
    } sk_state_t;

    // Difference is formed at COORD_W+1 bits signed, then folded to a magnitude.
    function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
        logic [COORD_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[COORD_W] ? (~d + 1'b1) : d;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous load, saturating at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    input  logic  inc_i,
    input  logic  load_i,
    input  bcd4_t load_val_i,
    output bcd4_t bcd_o
);

    bcd4_t cnt_q, cnt_d;
    logic  carry;

    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != 16'h9999)) begin
            carry = 1'b1;
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (cnt_q[4*d +: 4] == 4'd9) begin
                        cnt_d[4*d +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o = cnt_q;

endmodule

// File: rtl/score_keeper.sv
// Per-frame ball/block overlap scanner: awards points on hits, charges lives
// on unhit blocks reaching the bottom, and freezes once lives run out.
module score_keeper #(
    parameter int unsigned NUM_BALLS    = 2,
    parameter int unsigned NUM_BLOCKS   = 5,
    parameter int unsigned SCREEN_Y_MAX = game_pkg::SCREEN_Y_MAX,
    parameter int unsigned START_LIVES  = 3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic [10*NUM_BALLS-1:0]  ball_x,
    input  logic [10*NUM_BALLS-1:0]  ball_y,
    input  logic [10*NUM_BALLS-1:0]  ball_s,
    input  logic [10*NUM_BLOCKS-1:0] block_x,
    input  logic [10*NUM_BLOCKS-1:0] block_y,
    input  logic [10*NUM_BLOCKS-1:0] block_s,
    input  logic [NUM_BLOCKS-1:0]    block_ready,
    output logic [15:0]              score_bcd,
    output logic [1:0]               lives,
    output logic                     game_over,
    output logic                     hit_pulse,
    output logic [NUM_BLOCKS-1:0]    hit_mask
);
    import game_pkg::*;

    localparam int unsigned BallW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int unsigned BlkW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [COORD_W:0] YMax      = SCREEN_Y_MAX[COORD_W:0];
    localparam logic [1:0]       LivesInit = START_LIVES[1:0];

    sk_state_t              state_q, state_d;
    logic [2:0]             fc_sync_q;
    logic                   frame_start;
    logic [BallW-1:0]       ball_q, ball_d;
    logic [BlkW-1:0]        blk_q, blk_d;
    logic [NUM_BLOCKS-1:0]  hit_mask_q, hit_mask_d, miss_latch_q, miss_latch_d;
    logic [1:0]             lives_q, lives_d;
    logic                   pulse_q;
    logic                   scan_ok, last_ball, last_blk, rdy, hit, miss;
    logic [COORD_W:0]       reach, dx_abs, dy_abs, bottom;
    coord_t                 bx_a [NUM_BLOCKS];
    coord_t                 by_a [NUM_BLOCKS];
    coord_t                 bs_a [NUM_BLOCKS];
    coord_t                 xi_a [NUM_BALLS];
    coord_t                 yi_a [NUM_BALLS];
    coord_t                 si_a [NUM_BALLS];
    bcd4_t                  score;

    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
        assign bx_a[j] = block_x[COORD_W*j +: COORD_W];
        assign by_a[j] = block_y[COORD_W*j +: COORD_W];
        assign bs_a[j] = block_s[COORD_W*j +: COORD_W];
    end

    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
        assign xi_a[i] = ball_x[COORD_W*i +: COORD_W];
        assign yi_a[i] = ball_y[COORD_W*i +: COORD_W];
        assign si_a[i] = ball_s[COORD_W*i +: COORD_W];
    end

    // fc_sync_q[1] is the synchronised vsync; [2] holds its previous value.
    assign frame_start = fc_sync_q[1] & ~fc_sync_q[2];

    always_comb begin
        reach     = {1'b0, bs_a[blk_q]} + {1'b0, si_a[ball_q]};
        dx_abs    = abs_diff(bx_a[blk_q], xi_a[ball_q]);
        dy_abs    = abs_diff(by_a[blk_q], yi_a[ball_q]);
        bottom    = {1'b0, by_a[blk_q]} + {1'b0, bs_a[blk_q]};
        last_ball = (ball_q == BallW'(NUM_BALLS - 1));
        last_blk  = (blk_q == BlkW'(NUM_BLOCKS - 1));
        rdy       = block_ready[blk_q];
        // Once the last life is gone mid-scan, nothing else may change.
        scan_ok   = (state_q == SCAN) && (lives_q != 2'd0);
        hit       = scan_ok && rdy && !hit_mask_q[blk_q] &&
                    (dx_abs <= reach) && (dy_abs <= reach);
        miss      = scan_ok && last_ball && rdy && !hit_mask_q[blk_q] && !hit &&
                    !miss_latch_q[blk_q] && (bottom >= YMax);
    end

    always_comb begin
        state_d      = state_q;
        ball_d       = ball_q;
        blk_d        = blk_q;
        hit_mask_d   = hit_mask_q;
        miss_latch_d = miss_latch_q;
        lives_d      = lives_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SCAN;
                    ball_d  = '0;
                    blk_d   = '0;
                end
            end
            SCAN: begin
                if (scan_ok && !rdy) begin
                    hit_mask_d[blk_q]   = 1'b0;
                    miss_latch_d[blk_q] = 1'b0;
                end
                if (hit) begin
                    hit_mask_d[blk_q] = 1'b1;
                end
                if (miss) begin
                    miss_latch_d[blk_q] = 1'b1;
                    lives_d             = lives_q - 2'd1;
                end
                if (last_ball) begin
                    ball_d = '0;
                    if (last_blk) begin
                        state_d = (lives_d == 2'd0) ? OVER : IDLE;
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end else begin
                    ball_d = ball_q + 1'b1;
                end
            end
            OVER: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            fc_sync_q    <= '0;
            ball_q       <= '0;
            blk_q        <= '0;
            hit_mask_q   <= '0;
            miss_latch_q <= '0;
            lives_q      <= LivesInit;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fc_sync_q    <= {fc_sync_q[1:0], frame_clk};
            ball_q       <= ball_d;
            blk_q        <= blk_d;
            hit_mask_q   <= hit_mask_d;
            miss_latch_q <= miss_latch_d;
            lives_q      <= lives_d;
            pulse_q      <= hit;
        end
    end

    bcd_counter4 u_score (
        .Clk        (Clk),
        .Reset      (Reset),
        .inc_i      (hit),
        .load_i     (1'b0),
        .load_val_i ('0),
        .bcd_o      (score)
    );

    assign score_bcd = score;
    assign lives     = lives_q;
    assign game_over = (state_q == OVER);
    assign hit_pulse = pulse_q;
    assign hit_mask  = hit_mask_q;

endmodule
